// File: rtl/lap_stopwatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : lap_stopwatch_if
//  Description : Control/status bundle for the lap stopwatch core. The
//                master side (board logic or bench) drives the run/mode
//                levels and command pulses. The slave side (the core) returns
//                the displayed BCD digits and the lap-buffer status.
//  Ports       : enable, down, show_lap        - level controls (master out)
//                clear, load, lap, recall      - one-cycle pulses (master out)
//                load_val[19:0]                - {min,tensec,sec,deci,centi}
//                min..centisec[3:0]            - displayed digits (slave out)
//                lap_count, lap_idx [LW-1:0]   - laps stored / read index
//                lap_full, expired             - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface lap_stopwatch_if #(
   parameter int LAP_DEPTH = 4
);
   localparam int LW = $clog2(LAP_DEPTH + 1);

   logic          enable;
   logic          down;
   logic          clear;
   logic          load;
   logic [19:0]   load_val;
   logic          lap;
   logic          recall;
   logic          show_lap;

   logic [3:0]    min;
   logic [3:0]    tensec;
   logic [3:0]    sec;
   logic [3:0]    decisec;
   logic [3:0]    centisec;
   logic [LW-1:0] lap_count;
   logic [LW-1:0] lap_idx;
   logic          lap_full;
   logic          expired;

   modport master (
      output enable, down, clear, load, load_val, lap, recall, show_lap,
      input  min, tensec, sec, decisec, centisec,
      input  lap_count, lap_idx, lap_full, expired
   );

   modport slave (
      input  enable, down, clear, load, load_val, lap, recall, show_lap,
      output min, tensec, sec, decisec, centisec,
      output lap_count, lap_idx, lap_full, expired
   );
endinterface
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : lap_stopwatch
//  Description : Five-digit M:TS.DC stopwatch with up/down counting, preset
//                load with per-digit clamping, sticky expiry flag for
//                count-down, a LAP_DEPTH-entry lap capture buffer with
//                recall, and a centisecond tick divider.
//  Ports       : clk  - single clock, all state updates on rising edge
//                rst  - synchronous active-high reset, clears all state
//                sw   - lap_stopwatch_if.slave control/status bundle
//  Parameters  : TICK_DIV  - clk cycles per centisecond tick (>=1)
//                MIN_MAX   - largest minutes value (1..9)
//                LAP_DEPTH - number of lap slots (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module lap_stopwatch #(
   parameter int TICK_DIV  = 1,
   parameter int MIN_MAX   = 9,
   parameter int LAP_DEPTH = 4
) (
   input  wire            clk,
   input  wire            rst,
   lap_stopwatch_if.slave sw
);

   // -------------------------------------------------------------------------
   // Derived sizes and constants
   // -------------------------------------------------------------------------
   localparam int LW = $clog2(LAP_DEPTH + 1);
   // Address width of the lap RAM; at least one bit so LAP_DEPTH=1 still
   // has a legal index.
   localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int MEM_DEPTH = 1 << AW;
   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [DW-1:0] c_DIV_LAST  = DW'(TICK_DIV - 1);
   localparam logic [3:0]    c_MIN_MAX   = 4'(MIN_MAX);
   localparam logic [LW-1:0] c_LAP_DEPTH = LW'(LAP_DEPTH);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [DW-1:0] r_div;
   logic [3:0]    r_min;
   logic [3:0]    r_tensec;
   logic [3:0]    r_sec;
   logic [3:0]    r_deci;
   logic [3:0]    r_centi;
   logic          r_expired;
   logic [LW-1:0] r_lap_count;
   logic [LW-1:0] r_lap_idx;
   logic [19:0]   r_lap_mem [0:MEM_DEPTH-1];

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic          w_tick;
   logic [19:0]   w_live;
   logic          w_lap_full;
   logic          w_lap_we;
   logic          w_live_zero;

   // Up-count next value with ripple carry
   logic [3:0]    w_up_min, w_up_tensec, w_up_sec, w_up_deci, w_up_centi;
   logic          w_cy_centi, w_cy_deci, w_cy_sec, w_cy_tensec;

   // Down-count next value with ripple borrow
   logic [3:0]    w_dn_min, w_dn_tensec, w_dn_sec, w_dn_deci, w_dn_centi;
   logic          w_bw_centi, w_bw_deci, w_bw_sec, w_bw_tensec;
   logic          w_dn_zero;

   // Clamped load value
   logic [3:0]    w_ld_min, w_ld_tensec, w_ld_sec, w_ld_deci, w_ld_centi;

   // Recall index step
   logic [LW-1:0] w_idx_inc;
   logic [LW-1:0] w_idx_next;

   // Display selection
   logic          w_show;
   logic [19:0]   w_lap_rd;
   logic [19:0]   w_disp;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                              input logic [3:0] mx);
      clamp_digit = (d > mx) ? mx : d;
   endfunction

   assign w_live      = {r_min, r_tensec, r_sec, r_deci, r_centi};
   assign w_live_zero = (w_live == 20'd0);
   assign w_tick      = sw.enable && (r_div == c_DIV_LAST);
   assign w_lap_full  = (r_lap_count == c_LAP_DEPTH);
   // CLEAR wins over LAP; RESET is handled inside the RAM write process.
   assign w_lap_we    = sw.lap && !sw.clear && !w_lap_full;

   // Up counter: each digit rolls over at its own limit and carries upward.
   always_comb begin
      w_cy_centi  = (r_centi == 4'd9);
      w_up_centi  = w_cy_centi ? 4'd0 : r_centi + 4'd1;

      w_cy_deci   = w_cy_centi && (r_deci == 4'd9);
      w_up_deci   = r_deci;
      if (w_cy_centi) begin
         w_up_deci = (r_deci == 4'd9) ? 4'd0 : r_deci + 4'd1;
      end

      w_cy_sec    = w_cy_deci && (r_sec == 4'd9);
      w_up_sec    = r_sec;
      if (w_cy_deci) begin
         w_up_sec = (r_sec == 4'd9) ? 4'd0 : r_sec + 4'd1;
      end

      w_cy_tensec = w_cy_sec && (r_tensec == 4'd5);
      w_up_tensec = r_tensec;
      if (w_cy_sec) begin
         w_up_tensec = (r_tensec == 4'd5) ? 4'd0 : r_tensec + 4'd1;
      end

      // MIN_MAX:59.99 rolls to 0:00.00
      w_up_min    = r_min;
      if (w_cy_tensec) begin
         w_up_min = (r_min == c_MIN_MAX) ? 4'd0 : r_min + 4'd1;
      end
   end

   // Down counter: borrow cascade. Only applied when the live count is
   // non-zero, so the minutes digit never actually underflows.
   always_comb begin
      w_bw_centi  = (r_centi == 4'd0);
      w_dn_centi  = w_bw_centi ? 4'd9 : r_centi - 4'd1;

      w_bw_deci   = w_bw_centi && (r_deci == 4'd0);
      w_dn_deci   = r_deci;
      if (w_bw_centi) begin
         w_dn_deci = (r_deci == 4'd0) ? 4'd9 : r_deci - 4'd1;
      end

      w_bw_sec    = w_bw_deci && (r_sec == 4'd0);
      w_dn_sec    = r_sec;
      if (w_bw_deci) begin
         w_dn_sec = (r_sec == 4'd0) ? 4'd9 : r_sec - 4'd1;
      end

      w_bw_tensec = w_bw_sec && (r_tensec == 4'd0);
      w_dn_tensec = r_tensec;
      if (w_bw_sec) begin
         w_dn_tensec = (r_tensec == 4'd0) ? 4'd5 : r_tensec - 4'd1;
      end

      w_dn_min    = r_min;
      if (w_bw_tensec) begin
         w_dn_min = (r_min == 4'd0) ? c_MIN_MAX : r_min - 4'd1;
      end

      w_dn_zero   = ({w_dn_min, w_dn_tensec, w_dn_sec,
                      w_dn_deci, w_dn_centi} == 20'd0);
   end

   // Out-of-range preset digits saturate at their legal maximum.
   always_comb begin
      w_ld_min    = clamp_digit(sw.load_val[19:16], c_MIN_MAX);
      w_ld_tensec = clamp_digit(sw.load_val[15:12], 4'd5);
      w_ld_sec    = clamp_digit(sw.load_val[11:8],  4'd9);
      w_ld_deci   = clamp_digit(sw.load_val[7:4],   4'd9);
      w_ld_centi  = clamp_digit(sw.load_val[3:0],   4'd9);
   end

   // -------------------------------------------------------------------------
   // Tick divider: holds while disabled, restarts on CLEAR or LOAD.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
      end else if (sw.clear || sw.load) begin
         r_div <= '0;
      end else if (sw.enable) begin
         r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + DW'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Live count and expiry flag. Priority: RESET > CLEAR > LOAD > tick.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_min     <= 4'd0;
         r_tensec  <= 4'd0;
         r_sec     <= 4'd0;
         r_deci    <= 4'd0;
         r_centi   <= 4'd0;
         r_expired <= 1'b0;
      end else if (sw.clear) begin
         r_min     <= 4'd0;
         r_tensec  <= 4'd0;
         r_sec     <= 4'd0;
         r_deci    <= 4'd0;
         r_centi   <= 4'd0;
         r_expired <= 1'b0;
      end else if (sw.load) begin
         r_min     <= w_ld_min;
         r_tensec  <= w_ld_tensec;
         r_sec     <= w_ld_sec;
         r_deci    <= w_ld_deci;
         r_centi   <= w_ld_centi;
         r_expired <= 1'b0;
      end else if (w_tick) begin
         if (sw.down) begin
            // Count-down parks at zero; a tick at zero changes nothing,
            // including the expiry flag.
            if (!w_live_zero) begin
               r_min    <= w_dn_min;
               r_tensec <= w_dn_tensec;
               r_sec    <= w_dn_sec;
               r_deci   <= w_dn_deci;
               r_centi  <= w_dn_centi;
               if (w_dn_zero) begin
                  r_expired <= 1'b1;
               end
            end
         end else begin
            r_min    <= w_up_min;
            r_tensec <= w_up_tensec;
            r_sec    <= w_up_sec;
            r_deci   <= w_up_deci;
            r_centi  <= w_up_centi;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Lap buffer. The stored value is the pre-edge live count, so a same-edge
   // tick or LOAD does not affect what gets captured.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lap_count <= '0;
      end else if (sw.clear) begin
         r_lap_count <= '0;
      end else if (w_lap_we) begin
         r_lap_count <= r_lap_count + LW'(1);
      end
   end

   // RAM contents need no reset; only the fill count defines validity.
   always_ff @(posedge clk) begin
      if (!rst && w_lap_we) begin
         r_lap_mem[r_lap_count[AW-1:0]] <= w_live;
      end
   end

   // Read index walks the filled slots and wraps back to slot 0.
   assign w_idx_inc  = r_lap_idx + LW'(1);
   assign w_idx_next = (w_idx_inc == r_lap_count) ? '0 : w_idx_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lap_idx <= '0;
      end else if (sw.clear) begin
         r_lap_idx <= '0;
      end else if (sw.recall && (r_lap_count != '0)) begin
         r_lap_idx <= w_idx_next;
      end
   end

   // -------------------------------------------------------------------------
   // Display mux: purely combinational so SHOW_LAP takes effect immediately.
   // An empty buffer always shows the live count.
   // -------------------------------------------------------------------------
   assign w_show   = sw.show_lap && (r_lap_count != '0);
   assign w_lap_rd = r_lap_mem[r_lap_idx[AW-1:0]];
   assign w_disp   = w_show ? w_lap_rd : w_live;

   assign sw.min       = w_disp[19:16];
   assign sw.tensec    = w_disp[15:12];
   assign sw.sec       = w_disp[11:8];
   assign sw.decisec   = w_disp[7:4];
   assign sw.centisec  = w_disp[3:0];
   assign sw.lap_count = r_lap_count;
   assign sw.lap_idx   = r_lap_idx;
   assign sw.lap_full  = w_lap_full;
   assign sw.expired   = r_expired;

endmodule
`default_nettype wire
